// File: rtl/qenc_pkg.sv
// Shared types, widths and Gray-code step decoding for the quadrature encoder interface.
package qenc_pkg;
    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;

    localparam int POS_W = 32;
    localparam int ERR_W = 16;

    // Index of {a,b} along the forward cycle 00->10->11->01.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    function automatic step_t decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = phase(cur) - phase(prev);
        case (d)
            2'd0:    decode = STEP_NONE;
            2'd1:    decode = STEP_FWD;
            2'd3:    decode = STEP_REV;
            default: decode = STEP_ERR;
        endcase
    endfunction
endpackage

// File: rtl/qenc_if.sv
// Encoder channel inputs and decoded position/velocity outputs of quad_encoder_if.
interface qenc_if;
    import qenc_pkg::*;
    logic             sa;
    logic             sb;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] rot_v;
    logic             rot_v_valid;
    logic             dir;
    logic [ERR_W-1:0] err_cnt;

    modport master (output sa, sb, input pos, rot_v, rot_v_valid, dir, err_cnt);
    modport slave  (input sa, sb, output pos, rot_v, rot_v_valid, dir, err_cnt);
endinterface

// File: rtl/qenc_filter.sv
// Two-flop synchroniser followed by a stability filter for one encoder channel.
module qenc_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk100M,
    input  logic rstn,
    input  logic raw,
    output logic filt,
    output logic stable
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk100M) begin
        if (!rstn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any sample agreeing with the filtered value restarts the run.
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = (s2 == filt);
endmodule

// File: rtl/quad_encoder_if.sv
// Quadrature decoder: filtered A/B, x4 position, windowed velocity, direction.
// Define QENC_ERR_CNT_EN to build the illegal-transition counter.
module quad_encoder_if
    import qenc_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SAMPLE_HZ = 100,
    parameter int FILT_LEN  = 8
) (
    input  logic             clk100M,
    input  logic             rstn,
    input  logic             sa,
    input  logic             sb,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] rot_v,
    output logic             rot_v_valid,
    output logic             dir,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int WIN = CLK_FREQ / SAMPLE_HZ;
    localparam int WW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int CW  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILT_LEN - 1);

    logic             fa, fb, st_a, st_b;
    logic [1:0]       prev_ab;
    state_t           state, state_nxt;
    logic [CW-1:0]    ic, ic_nxt;
    step_t            step;
    logic [POS_W-1:0] step_v, acc;
    logic [WW-1:0]    wcnt;

    qenc_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk100M(clk100M), .rstn(rstn), .raw(sa), .filt(fa), .stable(st_a));
    qenc_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk100M(clk100M), .rstn(rstn), .raw(sb), .filt(fb), .stable(st_b));

    always_ff @(posedge clk100M) begin
        if (!rstn) begin
            state <= S_INIT;
            ic    <= '0;
        end else begin
            state <= state_nxt;
            ic    <= ic_nxt;
        end
    end

    // Leave S_INIT only after both channels settle, so power-up levels never count.
    always_comb begin
        state_nxt = state;
        ic_nxt    = ic;
        case (state)
            S_INIT: begin
                if (!(st_a && st_b)) begin
                    ic_nxt = '0;
                end else if (ic == CNT_MAX) begin
                    ic_nxt    = '0;
                    state_nxt = S_RUN;
                end else begin
                    ic_nxt = ic + 1'b1;
                end
            end
            default: ic_nxt = '0;
        endcase
    end

    always_comb begin
        step   = (state == S_RUN) ? decode(prev_ab, {fa, fb}) : STEP_NONE;
        step_v = '0;
        case (step)
            STEP_FWD: step_v = POS_W'(1);
            STEP_REV: step_v = '1;
            default:  step_v = '0;
        endcase
    end

    always_ff @(posedge clk100M) begin
        if (!rstn) begin
            prev_ab     <= 2'b00;
            pos         <= '0;
            dir         <= 1'b0;
            acc         <= '0;
            wcnt        <= '0;
            rot_v       <= '0;
            rot_v_valid <= 1'b0;
        end else begin
            prev_ab <= {fa, fb};
            pos     <= pos + step_v;
            if (step == STEP_FWD)      dir <= 1'b1;
            else if (step == STEP_REV) dir <= 1'b0;
            // The closing cycle's own step belongs to the window being closed.
            if (wcnt == WIN_LAST) begin
                rot_v       <= acc + step_v;
                acc         <= '0;
                wcnt        <= '0;
                rot_v_valid <= 1'b1;
            end else begin
                acc         <= acc + step_v;
                wcnt        <= wcnt + 1'b1;
                rot_v_valid <= 1'b0;
            end
        end
    end

`ifdef QENC_ERR_CNT_EN
    always_ff @(posedge clk100M) begin
        if (!rstn)                                 err_cnt <= '0;
        else if (step == STEP_ERR && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_quad_encoder_if.sv
// Randomised and directed bench for quad_encoder_if against a cycle-level behavioural model.
module tb_quad_encoder_if;
    import qenc_pkg::*;

    localparam int FL  = 4;
    localparam int WIN = 100;
`ifdef QENC_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk100M = 1'b0;
    logic rstn    = 1'b0;
    always #5 clk100M = ~clk100M;

    qenc_if bus();

    quad_encoder_if #(.CLK_FREQ(1000), .SAMPLE_HZ(10), .FILT_LEN(FL)) dut (
        .clk100M(clk100M), .rstn(rstn), .sa(bus.sa), .sb(bus.sb),
        .pos(bus.pos), .rot_v(bus.rot_v), .rot_v_valid(bus.rot_v_valid),
        .dir(bus.dir), .err_cnt(bus.err_cnt));

    int n_chk = 0, n_pass = 0;
    int rsum = 0, npulse = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // ra/rb hold raw samples taken at each edge, newest first; index 1 is what the
    // second synchroniser stage presents at the next edge.
    bit ra [FL+1];
    bit rb [FL+1];
    bit fa, fb, pa, pb, run, mvld, mdir, started;
    int srun, mwin, merr;
    logic [31:0] mpos, mrot, macc;

    // +1 forward, -1 reverse, 0 none, 2 illegal (both channels changed)
    function automatic int model_step(bit [1:0] p, bit [1:0] c);
        bit [1:0] seq [4];
        int ip = 0, ic = 0;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            if (seq[i] == p) ip = i;
            if (seq[i] == c) ic = i;
        end
        if (ip == ic)           return 0;
        if ((ip + 1) % 4 == ic) return 1;
        if ((ic + 1) % 4 == ip) return -1;
        return 2;
    endfunction

    always @(posedge clk100M) begin
        int  st;
        bit  flip_a, flip_b, stab;
        started = 1'b1;
        if (!rstn) begin
            for (int i = 0; i <= FL; i++) begin ra[i] = 1'b0; rb[i] = 1'b0; end
            fa = 0; fb = 0; pa = 0; pb = 0; run = 0; srun = 0;
            mwin = 0; macc = 0; mrot = 0; mvld = 0; mpos = 0; mdir = 0; merr = 0;
        end else begin
            st = run ? model_step({pa, pb}, {fa, fb}) : 0;
            if (st == 2) begin
                if (ERR_EN && merr < 65535) merr++;
                st = 0;
            end
            if (st == 1)  mdir = 1'b1;
            if (st == -1) mdir = 1'b0;
            mpos = mpos + 32'(st);
            if (mwin == WIN - 1) begin
                mrot = macc + 32'(st); macc = 0; mwin = 0; mvld = 1'b1;
            end else begin
                macc = macc + 32'(st); mwin++; mvld = 1'b0;
            end
            // A filtered channel flips only after FL consecutive disagreeing samples.
            flip_a = 1'b1; flip_b = 1'b1;
            for (int i = 1; i <= FL; i++) begin
                if (ra[i] == fa) flip_a = 1'b0;
                if (rb[i] == fb) flip_b = 1'b0;
            end
            stab = (ra[1] == fa) && (rb[1] == fb);
            srun = stab ? srun + 1 : 0;
            if (!run && srun >= FL) run = 1'b1;
            pa = fa; pb = fb;
            if (flip_a) fa = ~fa;
            if (flip_b) fb = ~fb;
            for (int i = FL; i > 0; i--) begin ra[i] = ra[i-1]; rb[i] = rb[i-1]; end
            ra[0] = bus.sa; rb[0] = bus.sb;
        end
    end

    always @(negedge clk100M) begin
        if (started) begin
            chk("pos", bus.pos, mpos);
            chk("rot_v", bus.rot_v, mrot);
            chk("rot_v_valid", 32'(bus.rot_v_valid), 32'(mvld));
            chk("dir", 32'(bus.dir), 32'(mdir));
            chk("err_cnt", 32'(bus.err_cnt), 32'(merr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk100M);
            if (bus.rot_v_valid) begin rsum += int'($signed(bus.rot_v)); npulse++; end
        end
    endtask

    task automatic enc_step(bit fwd, int hold);
        bit [1:0] seq [4];
        int k = 0;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) if (seq[i] == {bus.sa, bus.sb}) k = i;
        k = fwd ? (k + 1) % 4 : (k + 3) % 4;
        {bus.sa, bus.sb} = seq[k];
        cyc(hold);
    endtask

    task automatic wait_pulse(string nm);
        int np0 = npulse;
        int n = 0;
        while (npulse == np0 && n < 3 * WIN) begin cyc(1); n++; end
        if (npulse == np0) begin n_chk++; $display("FAIL %s: no rot_v_valid within %0d cycles", nm, n); end
    endtask

    task automatic wait_win(int w);
        int n = 0;
        while (mwin != w && n < 2 * WIN) begin cyc(1); n++; end
        if (mwin != w) begin n_chk++; $display("FAIL wait_win: window %0d never reached", w); end
    endtask

    initial begin
        int n;
        bit hit;
        bus.sa = 1'b1; bus.sb = 1'b1; rstn = 1'b0;
        cyc(3); rstn = 1'b1;
        cyc(20);
        chk("init_state", 32'(dut.state), 32'(S_RUN));
        chk("init_pos", bus.pos, 32'd0);
        chk("init_err", 32'(bus.err_cnt), 32'd0);

        // ten forward steps
        rsum = 0;
        for (int i = 0; i < 10; i++) enc_step(1'b1, 20);
        wait_pulse("fwd10_pulse");
        chk("fwd10_pos", bus.pos, 32'd10);
        chk("fwd10_dir", 32'(bus.dir), 32'd1);
        chk("fwd10_rot_sum", 32'(rsum), 32'd10);

        // short glitch on A is rejected
        bus.sa = ~bus.sa; cyc(3); bus.sa = ~bus.sa; cyc(20);
        chk("glitch_pos", bus.pos, 32'd10);
        chk("glitch_err", 32'(bus.err_cnt), 32'd0);

        // illegal double transition
        bus.sa = ~bus.sa; bus.sb = ~bus.sb; cyc(20);
        chk("illegal_pos", bus.pos, 32'd10);
        chk("illegal_err", 32'(bus.err_cnt), ERR_EN ? 32'd1 : 32'd0);

        // position wrap at the signed maximum
        @(posedge clk100M); #1;
        force dut.pos = 32'h7FFF_FFFF; mpos = 32'h7FFF_FFFF;
        @(posedge clk100M); #1;
        release dut.pos;
        cyc(2);
        enc_step(1'b1, 20);
        chk("wrap_pos", bus.pos, 32'h8000_0000);
        chk("wrap_dir", 32'(bus.dir), 32'd1);

        // step landing on the closing window cycle
        wait_pulse("align_pulse");
        wait_win(WIN - 1 - (2 + FL));
        enc_step(1'b1, 1);
        wait_pulse("edge_pulse");
        chk("edge_rot_v", bus.rot_v, 32'd1);
        wait_pulse("edge_next_pulse");
        chk("edge_next_rot_v", bus.rot_v, 32'd0);

        // reset mid-window discards partial accumulation
        wait_pulse("rst_align_pulse");
        for (int i = 0; i < 5; i++) enc_step(1'b0, 8);
        wait_win(50);
        rstn = 1'b0; cyc(2); rstn = 1'b1;
        chk("rst_rot_v", bus.rot_v, 32'd0);
        chk("rst_pos", bus.pos, 32'd0);
        chk("rst_vld", 32'(bus.rot_v_valid), 32'd0);
        n = 0; hit = 1'b0;
        while (!hit && n < 2 * WIN) begin cyc(1); n++; hit = bus.rot_v_valid; end
        chk("rst_first_pulse_at", 32'(n), 32'(WIN));
        chk("rst_first_rot_v", bus.rot_v, 32'd0);

        // randomised activity
        for (int it = 0; it < 120; it++) begin
            if (it == 60) begin rstn = 1'b0; cyc(2); rstn = 1'b1; cyc(10); end
            case ($urandom_range(0, 5))
                0, 1: enc_step(1'b1, $urandom_range(1, 15));
                2:    enc_step(1'b0, $urandom_range(1, 15));
                3: begin
                    if ($urandom_range(0, 1) == 0) begin
                        bus.sa = ~bus.sa; cyc($urandom_range(1, FL - 1)); bus.sa = ~bus.sa;
                    end else begin
                        bus.sb = ~bus.sb; cyc($urandom_range(1, FL - 1)); bus.sb = ~bus.sb;
                    end
                    cyc($urandom_range(1, 10));
                end
                4: begin bus.sa = ~bus.sa; bus.sb = ~bus.sb; cyc($urandom_range(1, 10)); end
                default: begin
                    for (int j = 0; j < 10; j++) begin
                        bus.sa = 1'($urandom); bus.sb = 1'($urandom); cyc(1);
                    end
                end
            endcase
        end
        cyc(30);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
